div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the EX stage of the 5-stage MIPS core. Implements DIV and DIVU.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Hands {remainder, quotient} back to EX for a HI/LO write through the existing whilo path.
- While busy_o is high, EX holds a stall request.

Parameters:
- WIDTH, 32, operand width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at accept
- opdata1_i  input  WIDTH  dividend; sampled at accept
- opdata2_i  input  WIDTH  divisor; sampled at accept
- start_i  input  1  request; level-held by EX until the result is consumed
- annul_i  input  1  abort the operation in flight (branch flush)
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; HI = remainder, LO = quotient
- ready_o  output  1  result_o is valid
- busy_o  output  1  division in progress (BYZERO or ON); drives the EX stall request

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=FREE, result_o=0, ready_o=0, busy_o=0, counter=0, internal dividend/divisor registers=0.
- Reset mid-operation takes priority over everything and returns to FREE with no result.
- States: FREE, BYZERO, ON, END. Encoding is 2 bits.
- FREE: if start_i=1 and annul_i=0, latch operands and signed flag (the "accept edge").
  - Divisor == 0 -> BYZERO.
  - Otherwise -> ON, counter=0.
  - In FREE, ready_o=0 and result_o=0.
- Signed operands: latch absolute values, using two's-complement negate when MSB=1.
  - Record q_neg = sign(op1) XOR sign(op2) and r_neg = sign(op1).
- ON: each cycle performs one restoring step on a (2*WIDTH+1)-bit partial register.
  - diff = upper(WIDTH+1) - divisor.
  - diff >= 0: upper=diff, shift in quotient bit 1. Otherwise shift in 0.
  - counter increments each cycle.
  - After WIDTH steps (counter == WIDTH) -> END.
  - On that transition, apply sign correction: negate the quotient if q_neg, negate the remainder if r_neg. Unsigned mode applies no correction.
- BYZERO: the next cycle goes to END with result_o=0 (quotient=0, remainder=0).
- END: ready_o=1, busy_o=0, and result_o is held stable.
  - Stays in END while start_i=1.
  - start_i=0 -> FREE, with ready_o=0 and result_o=0 in the next cycle.
- Latency:
  - Non-zero divisor: ready_o rises WIDTH+2 edges after the accept edge. That is 1 edge into ON, WIDTH iterations, then END. For WIDTH=32, 34 edges.
  - Zero divisor: ready_o rises 2 edges after the accept edge.
- Annul: annul_i=1 in BYZERO or ON -> FREE on the next edge. ready_o never rises and the partial result is discarded.
  - annul_i in FREE blocks acceptance.
  - annul_i in END is ignored; the result is already committed to EX.
- Operand changes: new start_i or operand changes while not in FREE are ignored. Operands are latched only at accept.
- Overflow case, signed MIN / -1: the quotient wraps to MIN (0x80000000 for W=32) and the remainder is 0. No exception is raised.
- Wrap and width rules: all arithmetic is modulo 2^WIDTH. Counter width is $clog2(WIDTH+1).
- Back-to-back: after END->FREE, a new start_i is accepted on the first FREE cycle.

Decomposition:
- defines.v holds:
  - The state encodings DIV_FREE / DIV_BYZERO / DIV_ON / DIV_END.
  - The DivStart / DivStop and DivResultReady / DivResultNotReady constants.
  - The EXE_DIV_OP / EXE_DIVU_OP aluop codes, as 8-bit values alongside the existing aluops.
- No sub-module. The abs/negate helpers are local functions; the restoring step is inline combinational logic.

Test Plan:
- Unsigned, W=32. DIVU 100/7, start held high.
  - Expect ready_o=1 at edge 34 after accept, with quotient=0x0000000E and remainder=0x00000002.
  - busy_o stays 1 for the 33 edges in between.
- Signed, W=32. DIV -100/7.
  - Expect quotient=0xFFFFFFF2 and remainder=0xFFFFFFFE.
  - DIV 100/-7 gives quotient=0xFFFFFFF2 and remainder=0x00000002.
- Divide by zero. DIVU 5/0 -> ready_o=1 at edge 2, result_o=0.
- Overflow. DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Annul and reset mid-operation.
  - Assert annul_i at iteration 10: FREE next edge, ready_o stays 0. A new DIVU 9/3 is accepted immediately and gives quotient=3, remainder=0.
  - Repeat using rst instead of annul_i; the result is the same.
- Handshake and parameter coverage.
  - Hold start_i high 5 cycles past END: ready_o and result_o stay stable. Drop start_i: ready_o=0 on the next cycle.
  - With WIDTH=8, DIVU 255/16 gives quotient=0x0F and remainder=0x0F at edge 10 after accept.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: FSM state codes,
// start/ready handshake levels and the aluop codes that select DIV/DIVU.
// Latency: n/a (definitions only). Backpressure: n/a.
package div_unit_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef logic [1:0] div_state_t;

   // Divider FSM encodings, kept as plain constants so legacy decode logic
   // that compares raw 2-bit codes still lines up.
   localparam div_state_t DIV_FREE   = 2'b00;
   localparam div_state_t DIV_BYZERO = 2'b01;
   localparam div_state_t DIV_ON     = 2'b10;
   localparam div_state_t DIV_END    = 2'b11;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // ALU operation codes that route an instruction to this unit.
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
// Latency: n/a (wires only). Backpressure: EX holds start_i until it has consumed result_o.
// Ports: signed_div_i/opdata1_i/opdata2_i/start_i/annul_i from EX; result_o/ready_o/busy_o back.
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
);

   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 busy_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, busy_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, busy_o
   );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient} for the HI/LO write.
// Latency: WIDTH+2 edges from accept to ready_o (2 edges for a zero divisor).
// Backpressure: result held in END until EX drops start_i; busy_o drives the EX stall.
// Ports: clk, rst (sync, active-high), div_bus (div_unit_if.slave).
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave div_bus
);

   localparam int            CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

   div_state_t         state;
   logic [CW-1:0]      counter;
   // {upper W+1 bits: running remainder with next dividend bit, lower W bits: dividend/quotient}
   logic [2*WIDTH:0]   partial;
   logic [2*WIDTH:0]   partial_step;
   logic [WIDTH-1:0]   divisor;
   logic               q_neg;
   logic               r_neg;
   logic [2*WIDTH-1:0] result;

   logic [WIDTH:0]     upper;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               op1_neg;
   logic               op2_neg;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? negate(v) : v;
   endfunction

   assign op1_neg = div_bus.signed_div_i & div_bus.opdata1_i[WIDTH-1];
   assign op2_neg = div_bus.signed_div_i & div_bus.opdata2_i[WIDTH-1];

   // One restoring step. When the trial subtraction succeeds the difference
   // always fits in WIDTH bits because the remainder stays below the divisor.
   assign upper = partial[2*WIDTH:WIDTH];
   assign diff  = upper[WIDTH-1:0] - divisor;

   always_comb begin
      partial_step = {partial[2*WIDTH-1:0], 1'b0};
      if (upper >= {1'b0, divisor}) begin
         partial_step = {diff, partial[WIDTH-1:0], 1'b1};
      end
   end

   // After WIDTH steps the remainder sits one bit above the quotient field.
   // abs(MIN) stays MIN, so MIN / -1 naturally wraps to MIN with remainder 0.
   assign quot_fix = q_neg ? negate(partial[WIDTH-1:0])         : partial[WIDTH-1:0];
   assign rem_fix  = r_neg ? negate(partial[2*WIDTH:WIDTH+1])   : partial[2*WIDTH:WIDTH+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_FREE;
         counter <= '0;
         partial <= '0;
         divisor <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            DIV_FREE: begin
               if (div_bus.start_i == DIV_START && !div_bus.annul_i) begin
                  q_neg   <= op1_neg ^ op2_neg;
                  r_neg   <= op1_neg;
                  divisor <= abs_val(op2_neg, div_bus.opdata2_i);
                  partial <= {{WIDTH{1'b0}}, abs_val(op1_neg, div_bus.opdata1_i), 1'b0};
                  counter <= '0;
                  state   <= (div_bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
               end
            end
            DIV_BYZERO: begin
               if (div_bus.annul_i) begin
                  state <= DIV_FREE;
               end else begin
                  result <= '0;
                  state  <= DIV_END;
               end
            end
            DIV_ON: begin
               if (div_bus.annul_i) begin
                  state <= DIV_FREE;
               end else if (counter == LAST_STEP) begin
                  result <= {rem_fix, quot_fix};
                  state  <= DIV_END;
               end else begin
                  partial <= partial_step;
                  counter <= counter + CW'(1);
               end
            end
            DIV_END: begin
               // annul_i is ignored here: EX has already committed the result.
               if (div_bus.start_i == DIV_STOP) begin
                  result <= '0;
                  state  <= DIV_FREE;
               end
            end
            default: state <= DIV_FREE;
         endcase
      end
   end

   assign div_bus.result_o = result;
   assign div_bus.ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
   assign div_bus.busy_o   = (state == DIV_BYZERO) || (state == DIV_ON);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus randomized DIV/DIVU against an arithmetic model.
// Latency: n/a. Backpressure: bench holds start_i until it has sampled the result.
// Two instances: WIDTH=32 and WIDTH=8 sharing clk/rst.
module tb_div_unit;
   import div_unit_pkg::*;

   logic clk;
   logic rst;

   div_unit_if #(.WIDTH(32)) bus32 ();
   div_unit_if #(.WIDTH(8))  bus8 ();

   div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .div_bus(bus32));
   div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .div_bus(bus8));

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, truncating toward zero, remainder takes
   // the dividend's sign, result reduced modulo 2^w. Divide by zero gives 0.
   function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r, mask;
      mask = (longint'(1) << w) - 1;
      if (b == 0) return '0;
      sa = longint'(a);
      sb = longint'(b);
      if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
      q = sa / sb;
      r = sa % sb;
      return 64'(((r & mask) << w) | (q & mask));
   endfunction

   // Drive one operation on the 32-bit unit. Called just after a negedge.
   task automatic run32(input logic [7:0] aluop, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit scramble,
                        output int lat, output int busy_cnt, output logic [63:0] res,
                        output bit held_ok, output logic rdy_drop, output logic [63:0] res_drop);
      bus32.signed_div_i = (aluop == EXE_DIV_OP);
      bus32.opdata1_i    = a;
      bus32.opdata2_i    = b;
      bus32.start_i      = 1'b1;
      bus32.annul_i      = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (scramble) begin
            bus32.opdata1_i    = $urandom;
            bus32.opdata2_i    = $urandom;
            bus32.signed_div_i = 1'($urandom);
         end
         if (!bus32.ready_o && bus32.busy_o) busy_cnt++;
      end while (!bus32.ready_o && lat < 200);
      res     = bus32.result_o;
      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         bus32.annul_i = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (!bus32.ready_o || bus32.result_o !== res) held_ok = 1'b0;
      end
      bus32.annul_i = 1'b0;
      bus32.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rdy_drop = bus32.ready_o;
      res_drop = bus32.result_o;
   endtask

   task automatic run8(input logic [7:0] aluop, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [15:0] res, output logic rdy_drop);
      bus8.signed_div_i = (aluop == EXE_DIV_OP);
      bus8.opdata1_i    = a;
      bus8.opdata2_i    = b;
      bus8.start_i      = 1'b1;
      bus8.annul_i      = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus8.ready_o && lat < 100);
      res = bus8.result_o;
      bus8.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rdy_drop = bus8.ready_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready32: got %b expected 0", bus32.ready_o); end
      n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy32: got %b expected 0", bus32.busy_o); end
      n_checks++; if (bus32.result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result32: got %h expected 0", bus32.result_o); end
      n_checks++; if (bus8.ready_o !== 1'b0 || bus8.busy_o !== 1'b0 || bus8.result_o !== 16'h0) begin
         n_fail++; $display("FAIL reset_w8: got ready=%b busy=%b result=%h expected 0/0/0", bus8.ready_o, bus8.busy_o, bus8.result_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      run32(EXE_DIVU_OP, 32'd100, 32'd7, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
      n_checks++; if (res !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL divu_result: got %h expected 000000020000000e", res); end
      n_checks++; if (bc != 33) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
      n_checks++; if (rdy !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL divu_release: got ready=%b result=%h expected 0/0", rdy, rd); end
   endtask

   task automatic test_signed();
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      run32(EXE_DIV_OP, -32'sd100, 32'd7, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (res !== 64'hFFFFFFFE_FFFFFFF2) begin n_fail++; $display("FAIL div_neg_dividend: got %h expected fffffffefffffff2", res); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_signed_latency: got %0d expected 34", lat); end
      run32(EXE_DIV_OP, 32'd100, -32'sd7, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (res !== 64'h00000002_FFFFFFF2) begin n_fail++; $display("FAIL div_neg_divisor: got %h expected 00000002fffffff2", res); end
   endtask

   task automatic test_div_zero();
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      run32(EXE_DIVU_OP, 32'd5, 32'd0, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 2", lat); end
      n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL divzero_result: got %h expected 0", res); end
      n_checks++; if (bc != 1) begin n_fail++; $display("FAIL divzero_busy: got %0d expected 1", bc); end
   endtask

   task automatic test_overflow();
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      run32(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (res !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_overflow: got %h expected 0000000080000000", res); end
   endtask

   // Abort mid-iteration via annul_i (use_rst=0) or rst (use_rst=1), then
   // check that a fresh DIVU 9/3 is accepted on the very next edge.
   task automatic test_abort(input bit use_rst);
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      bit never_ready = 1'b1;
      bus32.signed_div_i = 1'b0;
      bus32.opdata1_i    = 32'd1000;
      bus32.opdata2_i    = 32'd3;
      bus32.start_i      = 1'b1;
      bus32.annul_i      = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus32.ready_o !== 1'b0) never_ready = 1'b0;
      end
      n_checks++; if (bus32.busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before (rst=%0d): got %b expected 1", use_rst, bus32.busy_o); end
      if (use_rst) rst = 1'b1; else bus32.annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (bus32.ready_o !== 1'b0) never_ready = 1'b0;
      n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after (rst=%0d): got %b expected 0", use_rst, bus32.busy_o); end
      n_checks++; if (!never_ready) begin n_fail++; $display("FAIL abort_ready (rst=%0d): got 1 expected 0", use_rst); end
      rst = 1'b0;
      run32(EXE_DIVU_OP, 32'd9, 32'd3, 0, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (res !== 64'h00000000_00000003) begin n_fail++; $display("FAIL abort_followup_result (rst=%0d): got %h expected 0000000000000003", use_rst, res); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL abort_followup_latency (rst=%0d): got %0d expected 34", use_rst, lat); end
   endtask

   task automatic test_hold();
      int lat, bc; logic [63:0] res, rd; bit hk; logic rdy;
      run32(EXE_DIVU_OP, 32'd1000, 32'd7, 5, 1'b0, lat, bc, res, hk, rdy, rd);
      n_checks++; if (!hk) begin n_fail++; $display("FAIL hold_stable: got unstable ready/result expected stable"); end
      n_checks++; if (res !== ref_div(32, 1'b0, 32'd1000, 32'd7)) begin n_fail++; $display("FAIL hold_result: got %h expected %h", res, ref_div(32, 1'b0, 32'd1000, 32'd7)); end
      n_checks++; if (rdy !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL hold_release: got ready=%b result=%h expected 0/0", rdy, rd); end
   endtask

   task automatic test_width8();
      int lat; logic [15:0] res, exp16; logic rdy; logic [7:0] a, b; logic [7:0] op;
      run8(EXE_DIVU_OP, 8'd255, 8'd16, lat, res, rdy);
      n_checks++; if (lat != 10) begin n_fail++; $display("FAIL w8_latency: got %0d expected 10", lat); end
      n_checks++; if (res !== 16'h0F0F) begin n_fail++; $display("FAIL w8_result: got %h expected 0f0f", res); end
      for (int i = 0; i < 20; i++) begin
         op = ($urandom % 2) ? EXE_DIV_OP : EXE_DIVU_OP;
         a  = 8'($urandom_range(0, 255));
         b  = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         if (i == 3) begin a = 8'h80; b = 8'hFF; op = EXE_DIV_OP; end
         exp16 = 16'(ref_div(8, op == EXE_DIV_OP, 32'(a), 32'(b)));
         run8(op, a, b, lat, res, rdy);
         n_checks++; if (res !== exp16) begin n_fail++; $display("FAIL w8_rand_result op=%h %h/%h: got %h expected %h", op, a, b, res, exp16); end
         n_checks++; if (lat != ((b == 0) ? 2 : 10) || rdy !== 1'b0) begin
            n_fail++; $display("FAIL w8_rand_timing %h/%h: got lat=%0d release=%b expected lat=%0d release=0", a, b, lat, rdy, (b == 0) ? 2 : 10);
         end
      end
   endtask

   task automatic test_random();
      int lat, bc; logic [63:0] res, rd, exp64; bit hk; logic rdy;
      logic [31:0] a, b; logic [7:0] op;
      for (int i = 0; i < 25; i++) begin
         op = ($urandom % 2) ? EXE_DIV_OP : EXE_DIVU_OP;
         a  = ($urandom % 6 == 0) ? 32'h80000000 : 32'($urandom);
         case ($urandom % 8)
            0:       b = 32'h0;
            1:       b = 32'hFFFFFFFF;
            2:       b = 32'($urandom_range(1, 15));
            default: b = 32'($urandom);
         endcase
         exp64 = ref_div(32, op == EXE_DIV_OP, a, b);
         // Operands are scrambled while busy; only the accepted values may matter.
         run32(op, a, b, 0, 1'b1, lat, bc, res, hk, rdy, rd);
         n_checks++; if (res !== exp64) begin n_fail++; $display("FAIL rand_result op=%h %h/%h: got %h expected %h", op, a, b, res, exp64); end
         n_checks++; if (lat != ((b == 0) ? 2 : 34) || bc != lat - 1) begin
            n_fail++; $display("FAIL rand_timing %h/%h: got lat=%0d busy=%0d expected lat=%0d busy=lat-1", a, b, lat, bc, (b == 0) ? 2 : 34);
         end
         n_checks++; if (rdy !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL rand_release: got ready=%b result=%h expected 0/0", rdy, rd); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
      bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
      bus8.signed_div_i = 1'b0; bus8.opdata1_i = '0; bus8.opdata2_i = '0;
      bus8.start_i = 1'b0; bus8.annul_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_abort(1'b0);
      test_abort(1'b1);
      test_hold();
      test_width8();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
